// File: rtl/qs_q_pkg.sv
// Q-channel controller shared types: FSM state encoding and per-state output decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package qs_q_pkg;

    typedef enum logic [2:0] {
        Q_RUN      = 3'd0,
        Q_REQUEST  = 3'd1,
        Q_STOPPED  = 3'd2,
        Q_EXIT     = 3'd3,
        Q_CONTINUE = 3'd4
    } qstate_t;

    // Output bundle driven towards the device, registered alongside the state.
    typedef struct packed {
        logic qreqn;
        logic clk_en;
        logic stopped;
    } qout_t;

    localparam qout_t QOUT_RUN      = '{qreqn: 1'b1, clk_en: 1'b1, stopped: 1'b0};
    localparam qout_t QOUT_REQUEST  = '{qreqn: 1'b0, clk_en: 1'b1, stopped: 1'b0};
    localparam qout_t QOUT_STOPPED  = '{qreqn: 1'b0, clk_en: 1'b0, stopped: 1'b1};
    localparam qout_t QOUT_EXIT     = '{qreqn: 1'b1, clk_en: 1'b1, stopped: 1'b0};
    localparam qout_t QOUT_CONTINUE = '{qreqn: 1'b1, clk_en: 1'b1, stopped: 1'b0};

    function automatic qout_t qout_decode(input qstate_t st);
        qout_t o;
        case (st)
            Q_REQUEST:  o = QOUT_REQUEST;
            Q_STOPPED:  o = QOUT_STOPPED;
            Q_EXIT:     o = QOUT_EXIT;
            Q_CONTINUE: o = QOUT_CONTINUE;
            default:    o = QOUT_RUN;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/qs_idle_timer.sv
// Saturating count of consecutive idle cycles; flags the IDLE_CYCLES-th one.
// Latency: expire is combinational from idle and the registered count (same cycle).
// Backpressure: none; clear or any busy cycle restarts the run from zero.
//
// Ports: clk, reset (sync, active-high), clear (force count to 0),
//        idle (current cycle is idle), expire (this is the IDLE_CYCLES-th idle cycle).
module qs_idle_timer
    import qs_q_pkg::*;
#(
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = $clog2(IDLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic idle,
    output logic expire
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IDLE_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear || !idle) begin
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The count holds the number of idle cycles already completed, so the
    // current idle cycle is the IDLE_CYCLES-th when the count is one short.
    assign expire = idle && (cnt == CNT_LAST);

endmodule

// File: rtl/qs_q_ctrl.sv
// Q-channel initiator: requests quiescence after an idle run, gates the device clock while stopped.
// Latency: one cycle from any sampled qactive/qacceptn/qdeny to the outputs (all registered).
// Backpressure: a request is held until the device accepts or denies; no withdrawal.
//
// Ports: clk, reset (sync, active-high); device side qactive_i, qacceptn_i (active-low),
//        qdeny_i; outputs qreqn_o (active-low request), clk_en_o, stopped_o, state_o (qstate_t).
module qs_q_ctrl
    import qs_q_pkg::*;
#(
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = $clog2(IDLE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       qactive_i,
    input  logic       qacceptn_i,
    input  logic       qdeny_i,
    output logic       qreqn_o,
    output logic       clk_en_o,
    output logic       stopped_o,
    output logic [2:0] state_o
);

    qstate_t state_q;
    qstate_t state_nxt;
    qout_t   out_q;
    logic    idle_expire;

    // Counting only happens in RUN; holding the timer clear elsewhere means
    // every return to RUN starts a fresh idle run from zero.
    qs_idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != Q_RUN),
        .idle   (!qactive_i),
        .expire (idle_expire)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            Q_RUN: begin
                if (idle_expire) state_nxt = Q_REQUEST;
            end
            Q_REQUEST: begin
                // Accept takes priority over a simultaneous deny.
                if (!qacceptn_i)   state_nxt = Q_STOPPED;
                else if (qdeny_i)  state_nxt = Q_CONTINUE;
            end
            Q_STOPPED: begin
                // qacceptn rising here is a device fault; only new work wakes us.
                if (qactive_i) state_nxt = Q_EXIT;
            end
            Q_EXIT: begin
                if (qacceptn_i) state_nxt = Q_RUN;
            end
            Q_CONTINUE: begin
                if (!qdeny_i) state_nxt = Q_RUN;
            end
            default: state_nxt = Q_RUN;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    // and carry no combinational path from the device inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= Q_RUN;
            out_q   <= QOUT_RUN;
        end else begin
            state_q <= state_nxt;
            out_q   <= qout_decode(state_nxt);
        end
    end

    assign qreqn_o   = out_q.qreqn;
    assign clk_en_o  = out_q.clk_en;
    assign stopped_o = out_q.stopped;
    assign state_o   = state_q;

endmodule

// File: tb/tb_qs_q_ctrl.sv
// Directed bench for qs_q_ctrl with IDLE_CYCLES=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
// Each check compares {state_o, qreqn_o, clk_en_o, stopped_o} against a hand-derived value.
module tb_qs_q_ctrl;

    localparam int IDLE = 8;

    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_STOP = 3'd2;
    localparam logic [2:0] S_EXIT = 3'd3;
    localparam logic [2:0] S_CONT = 3'd4;

    // {state, qreqn, clk_en, stopped}
    localparam logic [5:0] E_RUN  = {S_RUN,  3'b110};
    localparam logic [5:0] E_REQ  = {S_REQ,  3'b010};
    localparam logic [5:0] E_STOP = {S_STOP, 3'b001};
    localparam logic [5:0] E_EXIT = {S_EXIT, 3'b110};
    localparam logic [5:0] E_CONT = {S_CONT, 3'b110};

    logic       clk = 1'b0;
    logic       reset;
    logic       qactive_i;
    logic       qacceptn_i;
    logic       qdeny_i;
    logic       qreqn_o;
    logic       clk_en_o;
    logic       stopped_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] obs;
    assign obs = {state_o, qreqn_o, clk_en_o, stopped_o};

    qs_q_ctrl #(.IDLE_CYCLES(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .qactive_i  (qactive_i),
        .qacceptn_i (qacceptn_i),
        .qdeny_i    (qdeny_i),
        .qreqn_o    (qreqn_o),
        .clk_en_o   (clk_en_o),
        .stopped_o  (stopped_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; qactive_i = 1'b1; qacceptn_i = 1'b1; qdeny_i = 1'b0;
        tick(); tick();
        if (obs !== E_RUN) begin
            $display("FAIL reset_state: got %b want %b", obs, E_RUN); n_err++;
        end
        n_cmp++;
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (obs !== E_RUN) begin
                $display("FAIL busy_hold[%0d]: got %b want %b", i, obs, E_RUN); n_err++;
            end
            n_cmp++;
        end
    endtask

    // From RUN with a cleared counter: qactive drops now; REQUEST appears after
    // exactly IDLE edges, then accept at cycle 10 stops the device at cycle 11.
    task automatic test_idle_accept();
        qactive_i = 1'b0;
        for (int i = 1; i <= IDLE; i++) begin
            tick();
            if (obs !== ((i == IDLE) ? E_REQ : E_RUN)) begin
                $display("FAIL idle_req[cyc %0d]: got %b want %b", i, obs,
                         (i == IDLE) ? E_REQ : E_RUN); n_err++;
            end
            n_cmp++;
        end
        tick();
        if (obs !== E_REQ) begin
            $display("FAIL req_hold: got %b want %b", obs, E_REQ); n_err++;
        end
        n_cmp++;
        tick();
        qacceptn_i = 1'b0;
        tick();
        if (obs !== E_STOP) begin
            $display("FAIL accept_stop: got %b want %b", obs, E_STOP); n_err++;
        end
        n_cmp++;
        // Device error: accept deasserts while stopped, must be ignored.
        qacceptn_i = 1'b1;
        tick();
        if (obs !== E_STOP) begin
            $display("FAIL stopped_ignore_acceptn: got %b want %b", obs, E_STOP); n_err++;
        end
        n_cmp++;
        qacceptn_i = 1'b0;
        tick();
    endtask

    task automatic test_wake();
        qactive_i = 1'b1;                 // cycle N
        tick();                           // N+1
        if (obs !== E_EXIT) begin
            $display("FAIL wake_exit: got %b want %b", obs, E_EXIT); n_err++;
        end
        n_cmp++;
        tick();                           // N+2, accept still low
        if (obs !== E_EXIT) begin
            $display("FAIL wake_exit_hold: got %b want %b", obs, E_EXIT); n_err++;
        end
        n_cmp++;
        tick();                           // N+3
        qacceptn_i = 1'b1;
        tick();                           // N+4
        if (obs !== E_RUN) begin
            $display("FAIL wake_run: got %b want %b", obs, E_RUN); n_err++;
        end
        n_cmp++;
        // A zero idle count shows up as a request after exactly IDLE idle cycles.
        qactive_i = 1'b0;
        for (int i = 1; i <= IDLE; i++) begin
            tick();
            if (obs !== ((i == IDLE) ? E_REQ : E_RUN)) begin
                $display("FAIL wake_count_clear[cyc %0d]: got %b want %b", i, obs,
                         (i == IDLE) ? E_REQ : E_RUN); n_err++;
            end
            n_cmp++;
        end
    endtask

    // Enters in REQUEST.
    task automatic test_deny();
        qactive_i = 1'b1;                 // ignored while requesting
        tick();
        if (obs !== E_REQ) begin
            $display("FAIL req_ignores_active: got %b want %b", obs, E_REQ); n_err++;
        end
        n_cmp++;
        qactive_i = 1'b0;
        qdeny_i = 1'b1;
        tick();
        if (obs !== E_CONT) begin
            $display("FAIL deny_continue: got %b want %b", obs, E_CONT); n_err++;
        end
        n_cmp++;
        tick(); tick();
        if (obs !== E_CONT) begin
            $display("FAIL deny_hold: got %b want %b", obs, E_CONT); n_err++;
        end
        n_cmp++;
        qdeny_i = 1'b0;
        tick();
        if (obs !== E_RUN) begin
            $display("FAIL deny_run: got %b want %b", obs, E_RUN); n_err++;
        end
        n_cmp++;
        for (int i = 1; i <= IDLE; i++) begin
            tick();
            if (obs !== ((i == IDLE) ? E_REQ : E_RUN)) begin
                $display("FAIL deny_rerequest[cyc %0d]: got %b want %b", i, obs,
                         (i == IDLE) ? E_REQ : E_RUN); n_err++;
            end
            n_cmp++;
        end
    endtask

    // Enters in REQUEST.
    task automatic test_simultaneous_and_reset();
        qacceptn_i = 1'b0;
        qdeny_i = 1'b1;
        tick();
        if (obs !== E_STOP) begin
            $display("FAIL accept_beats_deny: got %b want %b", obs, E_STOP); n_err++;
        end
        n_cmp++;
        qdeny_i = 1'b0;
        tick();
        reset = 1'b1; qacceptn_i = 1'b1; qactive_i = 1'b1;
        tick();
        if (obs !== E_RUN) begin
            $display("FAIL reset_from_stopped: got %b want %b", obs, E_RUN); n_err++;
        end
        n_cmp++;
        reset = 1'b0;
        tick();
    endtask

    // Enters in RUN with qactive high.
    task automatic test_interrupt();
        qactive_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (obs !== E_RUN) begin
                $display("FAIL intr_pre[cyc %0d]: got %b want %b", i, obs, E_RUN); n_err++;
            end
            n_cmp++;
        end
        qactive_i = 1'b1;
        tick();
        qactive_i = 1'b0;
        for (int i = 1; i <= IDLE; i++) begin
            tick();
            if (obs !== ((i == IDLE) ? E_REQ : E_RUN)) begin
                $display("FAIL intr_restart[cyc %0d]: got %b want %b", i, obs,
                         (i == IDLE) ? E_REQ : E_RUN); n_err++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_accept();
        test_wake();
        test_deny();
        test_simultaneous_and_reset();
        test_interrupt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qs_q_ctrl.md
# qs_q_ctrl

Power-controller (initiator) end of the Q-channel for the low-power channel. It watches the device's `qactive_i` and requests quiescence after a programmable run of idle cycles. It drives `qreqn_o`, tracks the device's `qacceptn_i`/`qdeny_i` responses, and gates the device clock enable while the device is stopped. It sits between the SoC power controller and the FIFO-backed channel device, which accepts only when its FIFO is drained.

## Interface
- `IDLE_CYCLES`, default 8: consecutive idle cycles (`qactive_i`=0) required before a request; legal range ≥1.
- `CNT_W`, default `$clog2(IDLE_CYCLES+1)`: idle counter width.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `qactive_i` in 1: device has pending or incoming work.
- `qacceptn_i` in 1: device accept, active-low; the device resets it to 1.
- `qdeny_i` in 1: device denies the quiescence request.
- `qreqn_o` out 1: quiescence request, active-low.
- `clk_en_o` out 1: device clock enable; 0 only while stopped.
- `stopped_o` out 1: high while in STOPPED.
- `state_o` out 3: current FSM state, encoded per `qstate_t`.

## Operation
- **Reset.** State RUN, idle count 0, `qreqn_o`=1, `clk_en_o`=1, `stopped_o`=0, `state_o`=RUN.
- **FSM states:** RUN, REQUEST, STOPPED, EXIT, CONTINUE. All outputs decode from the registered state only, with no input-to-output combinational path.
  - RUN: `qreqn_o`=1.
  - REQUEST: `qreqn_o`=0.
  - STOPPED: `qreqn_o`=0, `clk_en_o`=0, `stopped_o`=1.
  - EXIT: `qreqn_o`=1.
  - CONTINUE: `qreqn_o`=1.
- **RUN.**
  - Idle counter increments on each cycle with `qactive_i`=0 and saturates at `IDLE_CYCLES`.
  - It clears on any cycle with `qactive_i`=1.
  - RUN→REQUEST when `qactive_i`=0 and count == `IDLE_CYCLES`-1, i.e. on the `IDLE_CYCLES`-th consecutive idle cycle.
- **REQUEST.**
  - `qacceptn_i`=0 → STOPPED.
  - Otherwise, `qdeny_i`=1 → CONTINUE.
  - Accept and deny in the same cycle: accept wins.
  - `qactive_i` is ignored here; the request is never withdrawn before a response.
- **STOPPED.**
  - `qactive_i`=1 → EXIT.
  - `qacceptn_i` returning to 1 while stopped is a device error. It is ignored; the state stays STOPPED.
- **EXIT.**
  - `clk_en_o`=1 so the device can respond.
  - `qacceptn_i`=1 → RUN, idle count cleared.
- **CONTINUE** (denied path).
  - Wait for `qdeny_i`=0 → RUN, idle count cleared.
  - A new request therefore needs a fresh `IDLE_CYCLES` idle run.
- **Reset mid-handshake.** Any state returns to RUN next edge with `qreqn_o`=1. The device is expected to be reset together with this block.

## Timing
- `qreqn_o` falls in the cycle after the `IDLE_CYCLES`-th consecutive idle cycle. With `IDLE_CYCLES`=8 and `qactive_i` dropping at cycle 0, `qreqn_o`=0 from cycle 8.
- Each response is sampled at one edge and acted on in the next state, for a 1-cycle reaction:
  - `qacceptn_i`=0 sampled at edge N: `clk_en_o`=0 and `stopped_o`=1 from cycle N+1.
  - Wake: `qactive_i`=1 sampled at edge N gives `qreqn_o`=1 and `clk_en_o`=1 from cycle N+1. RUN follows 1 cycle after `qacceptn_i`=1 is sampled.
  - Deny: `qdeny_i`=1 at edge N gives `qreqn_o`=1 at N+1. RUN follows 1 cycle after `qdeny_i`=0 is sampled.
- Minimum stop–wake round trip: 3 cycles (REQUEST→STOPPED→EXIT→RUN).

## Structure
- Package `qs_q_pkg` holds:
  - `qstate_t`, a 3-bit enum: RUN=0, REQUEST=1, STOPPED=2, EXIT=3, CONTINUE=4.
  - Output decode constants.
- Sub-module `qs_idle_timer` holds the saturating idle counter.
  - Inputs: `clk`, `reset`, `clear`, `idle`.
  - Output: `expire`, which is high when the current cycle is the `IDLE_CYCLES`-th consecutive idle cycle.
- The FSM and output decode live in `qs_q_ctrl`.

## Test plan
- **Reset and busy hold.** Hold `reset` for 2 cycles, then keep `qactive_i`=1 for 50 cycles. Expect `qreqn_o`=1, `clk_en_o`=1, `stopped_o`=0 and `state_o`=0 throughout.
- **Idle request and accept** (`IDLE_CYCLES`=8). Drop `qactive_i` at cycle 0; `qreqn_o`=0 at cycle 8. Drive `qacceptn_i`=0 at cycle 10; `clk_en_o`=0 and `stopped_o`=1 at cycle 11.
- **Idle-run interruption.** Pulse `qactive_i`=1 at idle cycle 5. Expect no request until 8 further consecutive idle cycles have elapsed.
- **Wake.** From STOPPED, drive `qactive_i`=1 at cycle N. Expect `qreqn_o`=1 and `clk_en_o`=1 at N+1. Drive `qacceptn_i`=1 at N+3; `state_o`=RUN at N+4 and the idle count is 0.
- **Deny.** In REQUEST, drive `qdeny_i`=1. Expect `qreqn_o`=1 next cycle and `state_o`=CONTINUE. Drop `qdeny_i`; expect RUN, then a new request only after 8 further idle cycles.
- **Simultaneous response and reset.**
  - Accept and deny asserted together in REQUEST → STOPPED.
  - `reset` asserted in STOPPED → next cycle RUN, `qreqn_o`=1, `clk_en_o`=1.
